// File: rtl/param_alu_seq.sv
// param_alu_seq: single-issue ALU with valid/ready handshakes on both sides.
// Non-multiply ops finish in one cycle; MUL runs a WIDTH-step shift-add.
// A WIDTH-bit accumulator captures the low half of each accepted result and
// can stand in for operand A via acc_sel.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for a command
// BUSY  | multiply in progress, one shift-add step per cycle
// DONE  | out_valid high, result/flags held until out_ready
module param_alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           op,
    input  logic                 acc_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [3:0]           flags,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                 accept;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     opa;
    logic [CW-1:0]        step;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     diff;
    logic [SW-1:0]        shamt;
    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_carry;
    logic                 alu_ovf;
    logic [3:0]           alu_flags;

    logic [2*WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic [3:0]           mul_flags;

    assign accept = in_valid & in_ready;
    assign opa    = acc_sel ? acc : in_a;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (op == OP_MUL) ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (step == LAST_STEP) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle ALU for everything except MUL
    always_comb begin
        sum       = {1'b0, opa} + {1'b0, in_b};
        diff      = opa - in_b;
        shamt     = in_b[SW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = {{(WIDTH-1){1'b0}}, sum};
                alu_carry = sum[WIDTH];
                alu_ovf   = (opa[WIDTH-1] == in_b[WIDTH-1]) &&
                            (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = {{WIDTH{1'b0}}, diff};
                alu_carry = (opa < in_b);
                alu_ovf   = (opa[WIDTH-1] != in_b[WIDTH-1]) &&
                            (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND:  alu_res = {{WIDTH{1'b0}}, opa & in_b};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, opa | in_b};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, opa ^ in_b};
            OP_SHL:  alu_res = {{WIDTH{1'b0}}, opa} << shamt;
            OP_SHR:  alu_res = {{WIDTH{1'b0}}, opa >> shamt};
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], alu_ovf, alu_carry, (alu_res == '0)};
    end

    // One shift-add step; flags taken from the product as it completes
    always_comb begin
        prod_nxt  = prod + (mul_b[0] ? mul_a : '0);
        mul_flags = {prod_nxt[2*WIDTH-1], 1'b0, |prod_nxt[2*WIDTH-1:WIDTH],
                     (prod_nxt == '0)};
    end

    // Datapath: operand capture, multiply steps, result and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
            acc    <= '0;
            step   <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            prod   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            mul_a <= {{WIDTH{1'b0}}, opa};
                            mul_b <= in_b;
                            prod  <= '0;
                            step  <= '0;
                        end else begin
                            result <= alu_res;
                            flags  <= alu_flags;
                        end
                    end
                end
                S_BUSY: begin
                    prod  <= prod_nxt;
                    mul_a <= mul_a << 1;
                    mul_b <= mul_b >> 1;
                    step  <= step + CW'(1);
                    if (step == LAST_STEP) begin
                        result <= prod_nxt;
                        flags  <= mul_flags;
                    end
                end
                S_DONE: begin
                    if (out_ready) acc <= result[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu_seq.sv
// Scoreboard bench for param_alu_seq at WIDTH = 4: the stimulus thread
// pushes hand-computed results, the monitor compares on every out_valid cycle.
module tb_param_alu_seq;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     in_a, in_b;
    logic [2:0]       op;
    logic             acc_sel, in_valid, in_ready;
    logic [2*W-1:0]   result;
    logic [3:0]       flags;
    logic             out_valid, out_ready;

    typedef struct {
        logic [2*W-1:0] res;
        logic [3:0]     flg;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    param_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .op(op),
        .acc_sel(acc_sel), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .flags(flags), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented output against the head of the queue
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected output", 32'(out_valid), 32'd0);
            end else begin
                chk("result", 32'(result), 32'(q[0].res));
                chk("flags", 32'(flags), 32'(q[0].flg));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Issue one command with out_ready high and check its latency
    task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic as,
                         input logic [2*W-1:0] er, input logic [3:0] ef, input int lat);
        int cyc;
        op = o; in_a = a; in_b = b; acc_sel = as; in_valid = 1'b1;
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        q.push_back('{er, ef});
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 50) begin
            chk({name, " busy in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_a = '0; in_b = '0; op = '0; acc_sel = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flags", 32'(flags), 32'd0);

        //      name        op      A      B     acc  result  flags    lat
        issue("add 9+8",   3'b000, 4'h9, 4'h8, 1'b0, 8'h11, 4'b0110, 1);
        issue("add acc+2", 3'b000, 4'h7, 4'h2, 1'b1, 8'h03, 4'b0000, 1);
        issue("sub 3-5",   3'b001, 4'h3, 4'h5, 1'b0, 8'h0E, 4'b1010, 1);
        issue("mul 15*15", 3'b111, 4'hF, 4'hF, 1'b0, 8'hE1, 4'b1010, 5);
        issue("mul 6*7",   3'b111, 4'h6, 4'h7, 1'b0, 8'h2A, 4'b0010, 5);
        issue("mul 9*0",   3'b111, 4'h9, 4'h0, 1'b0, 8'h00, 4'b0001, 5);
        issue("add 7+1",   3'b000, 4'h7, 4'h1, 1'b0, 8'h08, 4'b1100, 1);
        issue("add f+1",   3'b000, 4'hF, 4'h1, 1'b0, 8'h10, 4'b0010, 1);
        issue("sub 8-1",   3'b001, 4'h8, 4'h1, 1'b0, 8'h07, 4'b0100, 1);
        issue("and",       3'b010, 4'hC, 4'hA, 1'b0, 8'h08, 4'b1000, 1);
        issue("or",        3'b011, 4'h5, 4'h2, 1'b0, 8'h07, 4'b0000, 1);
        issue("xor",       3'b100, 4'hF, 4'hF, 1'b0, 8'h00, 4'b0001, 1);
        issue("shr",       3'b110, 4'hB, 4'h6, 1'b0, 8'h02, 4'b0000, 1);
        issue("shl f<<3",  3'b101, 4'hF, 4'h7, 1'b0, 8'h78, 4'b1000, 1);

        // Backpressure: held result, no accept while DONE
        out_ready = 1'b0;
        op = 3'b000; in_a = 4'h1; in_b = 4'h1; acc_sel = 1'b0; in_valid = 1'b1;
        q.push_back('{8'h02, 4'b0000});
        @(posedge clk); #1;
        op = 3'b001; in_a = 4'h7; in_b = 4'h7;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp no reaccept in_ready", 32'(in_ready), 32'd1);
        chk("bp no reaccept out_valid", 32'(out_valid), 32'd0);
        q.push_back('{8'h00, 4'b0001});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp second accept", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Reset two cycles into a multiply; in_valid with rst is ignored
        op = 3'b111; in_a = 4'h6; in_b = 4'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; op = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort flags", 32'(flags), 32'd0);
        issue("acc after rst", 3'b000, 4'h5, 4'h0, 1'b1, 8'h00, 4'b0001, 1);
        issue("shl b<<3",      3'b101, 4'hB, 4'h3, 1'b0, 8'h58, 4'b1000, 1);

        repeat (3) @(posedge clk);
        chk("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
